addr_gen: RTL and testbench

ADDR_GEN -- requirements
Module: addr_gen

---
 rtl/addr_gen_pkg.sv | 11 +
 rtl/addr_gen.sv | 131 +++++++++++++
 tb/tb_addr_gen.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/addr_gen_pkg.sv
// Shared types for the strided address generator.
package addr_gen_pkg;

  // Sequencer states: waiting for start, emitting addresses, end-of-sequence pulse.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } addr_gen_state_e;

endpackage

// File: rtl/addr_gen.sv
// Strided address generator. Emits `count` addresses starting at `base`,
// stepping by `stride`. The add itself is done by an external adder wired
// through op_a/op_b/sum_in so it can be shared with neighbouring logic.
module addr_gen
  import addr_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic [DATA_WIDTH-1:0] stride,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  input  logic [DATA_WIDTH-1:0] sum_in,
  output logic [DATA_WIDTH-1:0] addr_out,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  wrapped
);

  addr_gen_state_e       state_q,     state_d;
  logic [DATA_WIDTH-1:0] addr_q,      addr_d;
  logic [DATA_WIDTH-1:0] stride_q,    stride_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  wrapped_q,   wrapped_d;

  logic hs;

  // Address is only offered while running; a beat moves on valid & ready.
  assign addr_valid = (state_q == ST_RUN);
  assign hs         = addr_valid & addr_ready;

  assign op_a     = addr_q;
  assign op_b     = stride_q;
  assign addr_out = addr_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign wrapped  = wrapped_q;

  // Next-state logic; clear takes priority over start and over a handshake.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    remaining_d = remaining_q;
    wrapped_d   = wrapped_q;

    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            wrapped_d = 1'b0;
            if (count != '0) begin
              addr_d      = base;
              stride_d    = stride;
              remaining_d = count;
              state_d     = ST_RUN;
            end else begin
              // Empty transfer: report completion without emitting anything.
              state_d = ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (hs) begin
            addr_d      = sum_in;
            remaining_d = remaining_q - 1'b1;
            // Unsigned sum smaller than the addend means the step carried out.
            if (sum_in < addr_q) wrapped_d = 1'b1;
            if (remaining_q == {{(CNT_WIDTH-1){1'b0}}, 1'b1}) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with asynchronous reset that abandons any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      remaining_q <= '0;
      wrapped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      remaining_q <= remaining_d;
      wrapped_q   <= wrapped_d;
    end
  end

`ifdef FORMAL
  logic past_ok_q;

  // Guards $past so the first cycle out of reset is not checked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) past_ok_q <= 1'b0;
    else     past_ok_q <= 1'b1;
  end

  // A stalled beat must present identical outputs on the next cycle.
  always_ff @(posedge clk) begin
    if (past_ok_q && !rst && $past(addr_valid && !addr_ready && !clear && !rst)) begin
      assert ($stable(addr_out) && $stable(op_a) && $stable(op_b) && $stable(remaining_q));
    end
  end

  // Nothing is offered while idle.
  always_comb begin
    if (state_q == ST_IDLE) assert (!addr_valid);
  end
`endif

endmodule

// File: tb/tb_addr_gen.sv
// Directed bench for addr_gen with an inline adder standing in for the sibling.
module tb_addr_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, clear, addr_ready;
  logic [7:0] base, stride, count;
  logic [7:0] op_a, op_b, sum_in, addr_out;
  logic       addr_valid, busy, done, wrapped;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  // External adder sibling.
  assign sum_in = op_a + op_b;

  addr_gen #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .base(base), .stride(stride), .count(count),
    .op_a(op_a), .op_b(op_b), .sum_in(sum_in),
    .addr_out(addr_out), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .busy(busy), .done(done), .wrapped(wrapped)
  );

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clear = 1'b0; addr_ready = 1'b1;
    base = 8'h00; stride = 8'h00; count = 8'h00;
    #3;
    total++;
    if ({addr_valid, busy, done, wrapped} !== 4'b0000 || op_a !== 8'h00 || op_b !== 8'h00 || addr_out !== 8'h00)
      $display("FAIL reset_outputs: got valid=%b busy=%b done=%b wr=%b a=%h b=%h out=%h, want all zero",
               addr_valid, busy, done, wrapped, op_a, op_b, addr_out);
    else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++;
    if (addr_valid !== 1'b0 || busy !== 1'b0) $display("FAIL reset_idle: valid=%b busy=%b want 0 0", addr_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    base = 8'h10; stride = 8'h04; count = 8'd4; addr_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (addr_valid !== 1'b1 || addr_out !== 8'h10 + 8'(4 * i) || op_b !== 8'h04 || busy !== 1'b1)
        $display("FAIL basic_beat%0d: valid=%b out=%h opb=%h busy=%b, want 1 %h 04 1",
                 i, addr_valid, addr_out, op_b, busy, 8'h10 + 8'(4 * i));
      else pass_cnt++;
      @(negedge clk);
    end
    total++;
    if (addr_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1 || wrapped !== 1'b0)
      $display("FAIL basic_done: valid=%b done=%b busy=%b wr=%b, want 0 1 1 0", addr_valid, done, busy, wrapped);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || addr_out !== 8'h20)
      $display("FAIL basic_idle: done=%b busy=%b out=%h, want 0 0 20", done, busy, addr_out);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a [3];
    logic       exp_w [3];
    exp_a[0] = 8'hF8; exp_a[1] = 8'h00; exp_a[2] = 8'h08;
    exp_w[0] = 1'b0;  exp_w[1] = 1'b1;  exp_w[2] = 1'b1;
    base = 8'hF8; stride = 8'h08; count = 8'd3; addr_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (addr_valid !== 1'b1 || addr_out !== exp_a[i] || wrapped !== exp_w[i])
        $display("FAIL wrap_beat%0d: valid=%b out=%h wr=%b, want 1 %h %b", i, addr_valid, addr_out, wrapped, exp_a[i], exp_w[i]);
      else pass_cnt++;
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || wrapped !== 1'b1) $display("FAIL wrap_done: done=%b wr=%b, want 1 1", done, wrapped);
    else pass_cnt++;
    @(negedge clk); @(negedge clk);
    total++;
    if (busy !== 1'b0 || wrapped !== 1'b1) $display("FAIL wrap_sticky: busy=%b wr=%b, want 0 1", busy, wrapped);
    else pass_cnt++;
  endtask

  task automatic test_zero_count();
    base = 8'h55; stride = 8'h01; count = 8'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++;
    if (addr_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1 || wrapped !== 1'b0)
      $display("FAIL zero_done: valid=%b done=%b busy=%b wr=%b, want 0 1 1 0", addr_valid, done, busy, wrapped);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (addr_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL zero_idle: valid=%b done=%b busy=%b, want 0 0 0", addr_valid, done, busy);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    base = 8'h20; stride = 8'h01; count = 8'd3; addr_ready = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (addr_valid !== 1'b1 || addr_out !== 8'h20 || op_a !== 8'h20 || op_b !== 8'h01)
        $display("FAIL stall_hold%0d: valid=%b out=%h a=%h b=%h, want 1 20 20 01", i, addr_valid, addr_out, op_a, op_b);
      else pass_cnt++;
      if (i < 2) @(negedge clk);
    end
    addr_ready = 1'b1;
    @(negedge clk);
    total++;
    if (addr_valid !== 1'b1 || addr_out !== 8'h21) $display("FAIL stall_beat1: valid=%b out=%h, want 1 21", addr_valid, addr_out);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (addr_valid !== 1'b1 || addr_out !== 8'h22) $display("FAIL stall_beat2: valid=%b out=%h, want 1 22", addr_valid, addr_out);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (done !== 1'b1 || addr_valid !== 1'b0) $display("FAIL stall_done: done=%b valid=%b, want 1 0", done, addr_valid);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_clear();
    base = 8'h40; stride = 8'h02; count = 8'd5; addr_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    total++;
    if (addr_out !== 8'h42) $display("FAIL clear_second: out=%h, want 42", addr_out);
    else pass_cnt++;
    clear = 1'b1; start = 1'b1;
    @(negedge clk); clear = 1'b0; start = 1'b0;
    total++;
    if (addr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || addr_out !== 8'h42)
      $display("FAIL clear_abort: valid=%b busy=%b done=%b out=%h, want 0 0 0 42", addr_valid, busy, done, addr_out);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL clear_nodone: done=%b busy=%b, want 0 0", done, busy);
    else pass_cnt++;
    base = 8'h80; stride = 8'h01; count = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++;
    if (addr_valid !== 1'b1 || addr_out !== 8'h80) $display("FAIL clear_restart: valid=%b out=%h, want 1 80", addr_valid, addr_out);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (done !== 1'b1) $display("FAIL clear_restart_done: done=%b, want 1", done);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    base = 8'h30; stride = 8'h03; count = 8'd6; addr_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    total++;
    if (addr_out !== 8'h33) $display("FAIL rstmid_pre: out=%h, want 33", addr_out);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total++;
    if (addr_valid !== 1'b0 || busy !== 1'b0 || addr_out !== 8'h00 || op_b !== 8'h00)
      $display("FAIL rstmid_async: valid=%b busy=%b out=%h b=%h, want 0 0 00 00", addr_valid, busy, addr_out, op_b);
    else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk);
    total++;
    if (addr_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_wait: valid=%b busy=%b, want 0 0", addr_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    base = 8'h50; stride = 8'h05; count = 8'd3; addr_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    base = 8'hAA; stride = 8'h11; count = 8'd9;
    @(negedge clk);
    total++;
    if (addr_out !== 8'h55 || op_b !== 8'h05) $display("FAIL ign_beat1: out=%h b=%h, want 55 05", addr_out, op_b);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (addr_out !== 8'h5A || addr_valid !== 1'b1) $display("FAIL ign_beat2: out=%h valid=%b, want 5a 1", addr_out, addr_valid);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (done !== 1'b1) $display("FAIL ign_done: done=%b, want 1", done);
    else pass_cnt++;
    start = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || addr_out !== 8'h5F) $display("FAIL ign_idle: busy=%b out=%h, want 0 5f", busy, addr_out);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_zero_count();
    test_stall();
    test_clear();
    test_rst_mid();
    test_start_ignored();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
